// File: rtl/rr_priority_arbiter.sv
// Round-robin arbiter with a rotating priority encoder, registered one-hot grant and an
// optional per-owner hold-time limit.
module rr_priority_arbiter #(
  parameter int unsigned NUM_REQ  = 8,
  parameter int unsigned ID_W     = 3,
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_REQ-1:0] req_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]    gnt_id_o,
  output logic               gnt_valid_o,
  output logic [4:0]         hold_cnt_o
);

  typedef enum logic [0:0] {StIdle, StOwn} state_e;

  state_e             state_q, state_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [4:0]         hold_q, hold_d;

  logic [ID_W-1:0] arb_ptr;
  logic [ID_W-1:0] scan_idx;
  logic [ID_W-1:0] win_id;
  logic            win_found;
  logic            hold_limit;
  logic            release_own;

  // On release the search starts just past the owner, matching the ptr update.
  assign arb_ptr = (state_q == StOwn) ? id_q + ID_W'(1) : ptr_q;

  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    scan_idx  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      scan_idx = arb_ptr + ID_W'(i);
      if (!win_found && req_i[scan_idx]) begin
        win_found = 1'b1;
        win_id    = scan_idx;
      end
    end
  end

  assign hold_limit  = (MAX_HOLD != 0) && (32'(hold_q) == MAX_HOLD - 1);
  assign release_own = !req_i[id_q] || hold_limit;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    gnt_d   = gnt_q;
    hold_d  = hold_q;
    unique case (state_q)
      StIdle: begin
        if (win_found) begin
          state_d = StOwn;
          id_d    = win_id;
          gnt_d   = NUM_REQ'(1) << win_id;
          hold_d  = '0;
        end
      end
      StOwn: begin
        if (release_own) begin
          ptr_d = id_q + ID_W'(1);
          if (win_found) begin
            id_d   = win_id;
            gnt_d  = NUM_REQ'(1) << win_id;
            hold_d = '0;
          end else begin
            state_d = StIdle;
            id_d    = '0;
            gnt_d   = '0;
            hold_d  = '0;
          end
        end else begin
          hold_d = (hold_q == 5'd31) ? 5'd31 : hold_q + 5'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      id_q    <= '0;
      gnt_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      gnt_q   <= gnt_d;
      hold_q  <= hold_d;
    end
  end

  assign gnt_o       = gnt_q;
  assign gnt_id_o    = id_q;
  assign gnt_valid_o = (state_q == StOwn);
  assign hold_cnt_o  = hold_q;

endmodule

// File: tb/tb_rr_priority_arbiter.sv
// Directed bench: a default-parameter arbiter (A) and a MAX_HOLD=4 arbiter (B) share clock
// and reset; expected grants are hand-derived from the rotating search rules.
module tb_rr_priority_arbiter;

  logic       clk;
  logic       rst;
  logic [7:0] req_a, req_b;
  logic [7:0] gnt_a, gnt_b;
  logic [2:0] id_a, id_b;
  logic       valid_a, valid_b;
  logic [4:0] hold_a, hold_b;

  int n_tests = 0;
  int n_fail  = 0;

  rr_priority_arbiter #(.NUM_REQ(8), .ID_W(3), .MAX_HOLD(16)) u_dut_a (
    .clk_i      (clk),
    .rst_i      (rst),
    .req_i      (req_a),
    .gnt_o      (gnt_a),
    .gnt_id_o   (id_a),
    .gnt_valid_o(valid_a),
    .hold_cnt_o (hold_a)
  );

  rr_priority_arbiter #(.NUM_REQ(8), .ID_W(3), .MAX_HOLD(4)) u_dut_b (
    .clk_i      (clk),
    .rst_i      (rst),
    .req_i      (req_b),
    .gnt_o      (gnt_b),
    .gnt_id_o   (id_b),
    .gnt_valid_o(valid_b),
    .hold_cnt_o (hold_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input logic [7:0] g, input int id, input logic v,
                       input int h);
    check_eq({tag, ".gnt"}, 32'(gnt_a), 32'(g));
    check_eq({tag, ".id"}, 32'(id_a), id);
    check_eq({tag, ".valid"}, 32'(valid_a), 32'(v));
    check_eq({tag, ".hold"}, 32'(hold_a), h);
  endtask

  task automatic chk_b(input string tag, input logic [7:0] g, input int id, input logic v,
                       input int h);
    check_eq({tag, ".gnt"}, 32'(gnt_b), 32'(g));
    check_eq({tag, ".id"}, 32'(id_b), id);
    check_eq({tag, ".valid"}, 32'(valid_b), 32'(v));
    check_eq({tag, ".hold"}, 32'(hold_b), h);
  endtask

  int         owners[5] = '{1, 4, 7, 1, 4};
  logic [7:0] one = 8'h01;

  initial begin
    // Reset held with all requests asserted
    rst   = 1'b1;
    req_a = 8'hFF;
    req_b = 8'h00;
    step();
    step();
    chk_a("reset_a", 8'h00, 0, 1'b0, 0);
    chk_b("reset_b", 8'h00, 0, 1'b0, 0);

    // Single request, one-cycle latency
    rst   = 1'b0;
    req_a = 8'h08;
    step();
    chk_a("single_grant", 8'h08, 3, 1'b1, 0);
    req_a = 8'h00;
    step();
    chk_a("single_drop", 8'h00, 0, 1'b0, 0);
    // ptr is now 4: with bits 0 and 5 requesting, 5 must win
    req_a = 8'h21;
    step();
    chk_a("ptr_after_drop", 8'h20, 5, 1'b1, 0);
    req_a = 8'h00;
    step();
    chk_a("idle_again", 8'h00, 0, 1'b0, 0);

    // Round-robin fairness from ptr=0
    rst = 1'b1;
    step();
    rst   = 1'b0;
    req_a = 8'h92;
    step();
    for (int k = 0; k < 5; k++) begin
      chk_a($sformatf("rr%0d_first", k), one << owners[k], owners[k], 1'b1, 0);
      req_a = 8'h92;
      step();
      chk_a($sformatf("rr%0d_second", k), one << owners[k], owners[k], 1'b1, 1);
      req_a = 8'h92 & ~(one << owners[k]);
      step();
    end
    req_a = 8'h00;
    step();

    // Hold limit 4 with two requesters
    req_b = 8'h05;
    for (int c = 0; c < 9; c++) begin
      step();
      begin
        int e;
        e = (c >= 4 && c < 8) ? 2 : 0;
        chk_b($sformatf("hold_c%0d", c), one << e, e, 1'b1, c % 4);
      end
    end

    // Solo requester 7 times out and is regranted
    req_b = 8'h80;
    for (int c = 0; c < 6; c++) begin
      step();
      chk_b($sformatf("solo_c%0d", c), 8'h80, 7, 1'b1, c % 4);
    end
    req_b = 8'h81;
    step();
    chk_b("wrap_h2", 8'h80, 7, 1'b1, 2);
    step();
    chk_b("wrap_h3", 8'h80, 7, 1'b1, 3);
    step();
    chk_b("wrap_to0", 8'h01, 0, 1'b1, 0);
    req_b = 8'h00;
    step();

    // Reset while owner 5 holds
    req_a = 8'h20;
    step();
    chk_a("mid_own5", 8'h20, 5, 1'b1, 0);
    req_a = 8'h21;
    step();
    chk_a("mid_hold", 8'h20, 5, 1'b1, 1);
    rst = 1'b1;
    step();
    chk_a("mid_reset", 8'h00, 0, 1'b0, 0);
    rst = 1'b0;
    step();
    chk_a("post_reset_ptr0", 8'h01, 0, 1'b1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_priority_arbiter.md
Name: rr_priority_arbiter

Overview:
- Round-robin arbiter that shares one downstream resource among NUM_REQ requesters.
- Combinational core is a rotating priority encoder; registered state holds the current owner, the rotation pointer and a hold-time counter.
- Sits in front of any shared datapath unit in the lab designs.
- Outputs a one-hot grant, an encoded owner index and a valid flag.

Parameters:
- NUM_REQ, 8, number of requesters (power of 2, 2..16)
- ID_W, 3, width of encoded owner index; equals log2(NUM_REQ)
- MAX_HOLD, 16, maximum consecutive grant cycles per owner; 0 disables the limit

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- req  input  NUM_REQ  request per requester; bit i high means requester i wants the resource
- gnt  output  NUM_REQ  one-hot grant, registered; all zero when no owner
- gnt_id  output  ID_W  encoded index of the current owner, registered
- gnt_valid  output  1  high while an owner holds the resource, registered
- hold_cnt  output  5  cycles the current owner has held the grant, minus 1; saturates at 31

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst; it overrides all other activity on that edge.
- Reset values: gnt=0, gnt_id=0, gnt_valid=0, hold_cnt=0, ptr=0, FSM in IDLE.
- Rotating search: scan indices ptr, ptr+1, ... NUM_REQ-1, 0, ... ptr-1, all modulo NUM_REQ. The first index with req high wins.
- FSM states: IDLE and OWN.
- IDLE:
  - If req is nonzero on an edge: next cycle gnt = onehot(winner), gnt_id = winner, gnt_valid = 1, hold_cnt = 0, state becomes OWN.
  - Latency from req to grant is exactly 1 cycle.
  - If req is zero: stay in IDLE with all outputs 0.
- OWN, owner k:
  - Release condition: req[k] == 0, or (MAX_HOLD != 0 and hold_cnt == MAX_HOLD-1).
  - If no release: hold the grant and set hold_cnt = hold_cnt+1, saturating at 31.
  - On release, set ptr = (k+1) mod NUM_REQ. Rearbitrate in the same cycle using the new ptr and the current req, with req[k] masked off only if req[k] == 0.
  - If any request remains: grant the new winner the next cycle with hold_cnt = 0. There is no idle bubble between owners.
  - If no request remains: go to IDLE and clear all outputs the next cycle.
  - Timeout with only k requesting: k is regranted and hold_cnt restarts at 0. gnt_valid stays high throughout.
- Invariants:
  - With MAX_HOLD != 0, a single grant lasts at most MAX_HOLD consecutive cycles.
  - gnt always has at most one bit set, and gnt[gnt_id] == gnt_valid.
- Requests from non-owners during OWN are ignored until release; they do not affect gnt.
- Reset mid-ownership: on the next edge all outputs go to 0 and ptr returns to 0, regardless of req.
- Wrap-around: owner NUM_REQ-1 releases -> ptr = 0.
- Each requester is granted at most once before any other pending requester is granted. Starvation bound: (NUM_REQ-1) × MAX_HOLD cycles.

Test Plan:
- Reset: hold rst=1 for 2 cycles with req=8'hFF -> gnt=0, gnt_id=0, gnt_valid=0, hold_cnt=0.
- Single request: after reset set req=8'b0000_1000 -> one cycle later gnt=8'h08, gnt_id=3, gnt_valid=1. Drop req -> one cycle later gnt_valid=0, and ptr=4 observed on the next arbitration.
- Round-robin fairness: hold req=8'b1001_0010 and have each owner drop its bit for 1 cycle after 2 cycles of grant, then reassert. Grant order is 1, 4, 7, 1, 4 with no idle cycle between owners.
- Hold limit: MAX_HOLD=4, hold req=8'b0000_0101 constant -> owner 0 for exactly 4 cycles (hold_cnt 0..3), then owner 2 for 4 cycles, then owner 0.
- Solo timeout and wrap: MAX_HOLD=4, req=8'h80 held -> gnt_id=7 continuously with hold_cnt cycling 0,1,2,3,0. Then add req bit 0 -> the next grant after release goes to 0.
- Reset mid-operation: assert rst for 1 cycle while owner 5 holds, with req=8'h21 -> outputs 0 on the next edge. After rst drops, the grant goes to 0 (ptr=0), not 5.
